if_stage: RTL

IF_STAGE -- requirements
Module: IF_Stage

---
 rtl/if_stage_pkg.sv | 23 ++
 rtl/if_stage_instruction_memory.sv | 32 +++
 rtl/if_stage.sv | 94 +++++++++
 3 files changed

// File: rtl/if_stage_pkg.sv
// Shared constants for the instruction-fetch stage: word size, default reset
// address, next-PC select encoding and the boot program image.
package if_stage_pkg;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // Next-PC source chosen by the fetch-stage priority logic
    typedef enum logic [1:0] {
        SEL_HOLD   = 2'd0,
        SEL_BRANCH = 2'd1,
        SEL_INC    = 2'd2
    } next_pc_sel_e;

    // Program image: word i holds "mov r0, #i" (ARM encoding 0xE3A0_00ii),
    // which makes every fetched word identify its own address.
    function automatic logic [31:0] prog_word(input int unsigned idx);
        logic [31:0] w_idx;
        w_idx     = 32'(idx);
        prog_word = 32'hE3A0_0000 | {24'h0, w_idx[7:0]};
    endfunction

endpackage

// File: rtl/if_stage_instruction_memory.sv
// Combinational, word-addressed instruction ROM. Words at or beyond DEPTH
// read as zero so a runaway fetch returns a harmless all-zero word.
module Instruction_Memory
    import if_stage_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic [29:0] i_word_addr,
    output logic [31:0] o_data
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [31:0] w_mem [DEPTH];
    logic        w_in_range;

    // ROM contents are constant wires built from the program image
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rom
        assign w_mem[gi] = prog_word(gi);
    end

    assign w_in_range = ({2'b00, i_word_addr} < 32'(DEPTH));

    // Bounds-checked read; out-of-range addresses return zero
    always_comb begin
        o_data = 32'h0000_0000;
        if (w_in_range) begin
            o_data = w_mem[i_word_addr[AW-1:0]];
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC priority mux, instruction ROM
// and optional performance counters (enable with `define IF_PERF_CNT_EN).
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int unsigned IMEM_DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        SRAM_freeze,
    input  logic        Branch_taken,
    input  logic [31:0] BranchAddr,
    output logic [31:0] PC,
    output logic [31:0] Instruction,
    output logic [31:0] fetch_cnt,
    output logic [31:0] stall_cnt,
    output logic [31:0] redirect_cnt
);

    logic [31:0]  pc_q;
    logic [31:0]  w_pc_inc;
    next_pc_sel_e w_sel;

    assign w_pc_inc = pc_q + 32'(WORD_BYTES);
    assign PC       = w_pc_inc;

    // Memory stall outranks a branch: the stalled execute stage re-presents it
    always_comb begin
        w_sel = SEL_INC;
        if (SRAM_freeze) begin
            w_sel = SEL_HOLD;
        end else if (Branch_taken) begin
            w_sel = SEL_BRANCH;
        end else if (freeze) begin
            w_sel = SEL_HOLD;
        end
    end

    // Fetch-address register; branch target stored verbatim, low bits included
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            case (w_sel)
                SEL_BRANCH: pc_q <= BranchAddr;
                SEL_INC:    pc_q <= w_pc_inc;
                default:    pc_q <= pc_q;
            endcase
        end
    end

    Instruction_Memory #(
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .i_word_addr (pc_q[31:2]),
        .o_data      (Instruction)
    );

`ifdef IF_PERF_CNT_EN
    logic [31:0] r_fetch_cnt;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_redirect_cnt;

    // Event counters; all wrap naturally at 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt    <= 32'd0;
            r_stall_cnt    <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (w_sel != SEL_HOLD) begin
                r_fetch_cnt <= r_fetch_cnt + 32'd1;
            end
            if (w_sel == SEL_HOLD) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_sel == SEL_BRANCH) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign fetch_cnt    = r_fetch_cnt;
    assign stall_cnt    = r_stall_cnt;
    assign redirect_cnt = r_redirect_cnt;
`else
    assign fetch_cnt    = 32'd0;
    assign stall_cnt    = 32'd0;
    assign redirect_cnt = 32'd0;
`endif

endmodule
